// File: rtl/prbs_pkg.sv
// prbs_pkg: definitions shared by the 13-bit PRBS generator and checker.
//   prbs_state_t : checker FSM states (SEED, VERIFY, LOCKED)
//   LFSR13_WIDTH : LFSR length
//   LFSR13_TAPS  : Fibonacci feedback tap mask (bits 12, 3, 2, 0)
package prbs_pkg;

  localparam int          LFSR13_WIDTH = 13;
  localparam logic [12:0] LFSR13_TAPS  = 13'h100D;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } prbs_state_t;

endpackage

// File: rtl/prbs_checker_lfsr_predict.sv
// lfsr_predict: next-bit prediction of a Fibonacci LFSR.
//   sr        : current shift register contents, sr[0] newest bit
//   predicted : parity of sr & TAPS, i.e. the bit the generator emits next
// Purely combinational so the generator can reuse it as its feedback term.
module lfsr_predict
  import prbs_pkg::*;
#(
  parameter int                 WIDTH = LFSR13_WIDTH,
  parameter logic [WIDTH-1:0]   TAPS  = LFSR13_TAPS
) (
  input  logic [WIDTH-1:0] sr,
  output logic             predicted
);

  assign predicted = ^(sr & TAPS);

endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising checker for the 13-bit PRBS stream.
//   clock     : rising-edge system clock
//   reset     : synchronous, active-low reset
//   in_bit    : received stream bit
//   in_valid  : in_bit is consumed only when high
//   clear_cnt : synchronous clear of err_count
//   locked    : checker is in LOCKED
//   bit_err   : one-cycle pulse per mismatched bit while LOCKED
//   lock_lost : one-cycle pulse on the LOCKED-to-SEED transition
//   err_count : saturating count of bit errors
//   fsm_state : current FSM state, for debug and checkers
// Handshake: a bit is transferred on every rising edge where in_valid is 1;
// there is no back-pressure. All outputs are registered and reflect the bit
// sampled at the previous edge; cycles with in_valid=0 change nothing except
// that the pulses return to 0 and clear_cnt still acts.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int               WIDTH      = LFSR13_WIDTH,
  parameter logic [WIDTH-1:0] TAPS       = LFSR13_TAPS,
  parameter int               GOOD_LEN   = 16,
  parameter int               WINDOW     = 64,
  parameter int               ERR_THRESH = 4,
  parameter int               CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             bit_err,
  output logic             lock_lost,
  output logic [CNT_W-1:0] err_count,
  output prbs_state_t      fsm_state
);

  localparam int SEED_W = $clog2(WIDTH + 1);
  localparam int GOOD_W = $clog2(GOOD_LEN + 1);
  localparam int WIN_W  = $clog2(WINDOW);
  localparam int ERR_W  = $clog2(ERR_THRESH + 1);

  prbs_state_t       state;
  logic [WIDTH-1:0]  sr;
  logic [SEED_W-1:0] seed_cnt;
  logic [GOOD_W-1:0] good_cnt;
  logic [WIN_W-1:0]  win_cnt;
  logic [ERR_W-1:0]  win_err;

  logic              predicted;
  logic              mismatch;
  logic [WIDTH-1:0]  sr_rx;
  logic [SEED_W-1:0] seed_next;
  logic [GOOD_W-1:0] good_next;
  logic              win_wrap;
  logic [ERR_W-1:0]  win_err_next;

  lfsr_predict #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_predict (
    .sr        (sr),
    .predicted (predicted)
  );

  always_comb begin
    mismatch  = (in_bit != predicted);
    sr_rx     = {sr[WIDTH-2:0], in_bit};
    seed_next = seed_cnt + SEED_W'(1);
    good_next = good_cnt + GOOD_W'(1);
    win_wrap  = (win_cnt == WIN_W'(WINDOW - 1));
    // An error on the wrap bit belongs to the window that starts afterwards.
    win_err_next = (win_wrap ? '0 : win_err) + ERR_W'(mismatch);
  end

  assign fsm_state = state;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= SEED;
      sr        <= '0;
      seed_cnt  <= '0;
      good_cnt  <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      locked    <= 1'b0;
      bit_err   <= 1'b0;
      lock_lost <= 1'b0;
      err_count <= '0;
    end else begin
      bit_err   <= 1'b0;
      lock_lost <= 1'b0;
      // Overridden below when an error is counted on this same edge, so a
      // clear coinciding with an error leaves a count of one.
      if (clear_cnt) err_count <= '0;

      if (in_valid) begin
        case (state)
          SEED: begin
            sr <= sr_rx;
            if (seed_next == SEED_W'(WIDTH)) begin
              // An all-zero register is the LFSR lock-up state: never valid.
              if (sr_rx == '0) begin
                seed_cnt <= '0;
              end else begin
                seed_cnt <= seed_next;
                good_cnt <= '0;
                state    <= VERIFY;
              end
            end else begin
              seed_cnt <= seed_next;
            end
          end

          VERIFY: begin
            sr <= sr_rx;
            if (!mismatch) begin
              good_cnt <= good_next;
              if (good_next == GOOD_W'(GOOD_LEN)) begin
                state   <= LOCKED;
                locked  <= 1'b1;
                win_cnt <= '0;
                win_err <= '0;
              end
            end else begin
              state    <= SEED;
              seed_cnt <= '0;
            end
          end

          LOCKED: begin
            // Shift the prediction so a corrupted bit does not poison sr.
            sr      <= {sr[WIDTH-2:0], predicted};
            win_cnt <= win_wrap ? '0 : win_cnt + WIN_W'(1);
            if (mismatch) begin
              bit_err <= 1'b1;
              if (clear_cnt)       err_count <= CNT_W'(1);
              else if (~&err_count) err_count <= err_count + CNT_W'(1);
            end
            if (win_err_next == ERR_W'(ERR_THRESH)) begin
              state     <= SEED;
              locked    <= 1'b0;
              lock_lost <= 1'b1;
              seed_cnt  <= '0;
              win_err   <= '0;
            end else begin
              win_err <= win_err_next;
            end
          end

          default: begin
            state    <= SEED;
            seed_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: directed scenarios for prbs_checker. A driver task applies
// one cycle of stimulus and queues the hand-derived expected outputs; a
// monitor on the falling edge pops and compares them.
module tb_prbs_checker;
  import prbs_pkg::*;

  localparam int W = 21;  // {state[1:0], locked, bit_err, lock_lost, err_count[15:0]}

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_bit = 1'b0;
  logic        in_valid = 1'b0;
  logic        clear_cnt = 1'b0;
  logic        locked;
  logic        bit_err;
  logic        lock_lost;
  logic [15:0] err_count;
  prbs_state_t fsm_state;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [12:0]  gen_sr;

  logic [W-1:0] mon_e;
  logic [W-1:0] mon_a;
  string        mon_t;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  prbs_checker dut (
    .clock     (clock),
    .reset     (reset),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .clear_cnt (clear_cnt),
    .locked    (locked),
    .bit_err   (bit_err),
    .lock_lost (lock_lost),
    .err_count (err_count),
    .fsm_state (fsm_state)
  );

  // ---------------- driver tasks ----------------
  // Reference generator: emits parity(sr & taps) and shifts it into bit 0.
  task automatic gen_bit(output logic b);
    b      = ^(gen_sr & LFSR13_TAPS);
    gen_sr = {gen_sr[11:0], b};
  endtask

  task automatic drive(input logic rst_n, input logic b, input logic v,
                       input logic clr, input prbs_state_t es,
                       input logic eb, input logic ell,
                       input logic [15:0] ec, input string tag);
    logic el;
    el = (es == LOCKED);
    @(negedge clock);
    reset     = rst_n;
    in_bit    = b;
    in_valid  = v;
    clear_cnt = clr;
    @(posedge clock);
    exp_q.push_back({es, el, eb, ell, ec});
    tag_q.push_back(tag);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, SEED, 1'b0, 1'b0, 16'd0, "reset");
    drive(1'b0, 1'b1, 1'b1, 1'b0, SEED, 1'b0, 1'b0, 16'd0, "reset");
    gen_sr = 13'h000F;
  endtask

  // Acquisition timeline in valid bits since seeding started:
  // 13 seed bits, then 16 good predictions.
  function automatic prbs_state_t acq(input int v);
    if (v < 13)      return SEED;
    else if (v < 29) return VERIFY;
    else             return LOCKED;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      mon_a = {fsm_state, locked, bit_err, lock_lost, err_count};
      checks++;
      if (mon_a !== mon_e) begin
        errors++;
        $display("FAIL %s @%0t: got state=%0d locked=%b bit_err=%b lock_lost=%b err_count=%0d, expected state=%0d locked=%b bit_err=%b lock_lost=%b err_count=%0d",
                 mon_t, $time, mon_a[20:19], mon_a[18], mon_a[17], mon_a[16], mon_a[15:0],
                 mon_e[20:19], mon_e[18], mon_e[17], mon_e[16], mon_e[15:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic        b;
    logic        inj;
    logic        clr;
    logic [15:0] ec;
    int          v;
    prbs_state_t es;

    // Lock acquisition on a clean stream, then 1000 bits without errors.
    do_reset();
    for (int n = 1; n <= 1000; n++) begin
      gen_bit(b);
      drive(1'b1, b, 1'b1, 1'b0, acq(n), 1'b0, 1'b0, 16'd0, "acquire");
    end

    // Single inverted bit while locked.
    do_reset();
    for (int n = 1; n <= 400; n++) begin
      gen_bit(b);
      inj = (n == 200);
      ec  = (n >= 200) ? 16'd1 : 16'd0;
      drive(1'b1, b ^ inj, 1'b1, 1'b0, acq(n), inj, 1'b0, ec, "single_err");
    end

    // Four errors inside window 286..349 -> lock lost after bit 330, relock at 359.
    do_reset();
    ec = 16'd0;
    for (int n = 1; n <= 380; n++) begin
      gen_bit(b);
      inj = (n == 300) || (n == 310) || (n == 320) || (n == 330);
      if (inj) ec = ec + 16'd1;
      es = (n < 330) ? acq(n) : acq(n - 330);
      drive(1'b1, b ^ inj, 1'b1, 1'b0, es, inj, 1'b1 && (n == 330), ec, "loss_of_lock");
    end

    // Window wrap: bit 93 is the last bit of window 30..93; its error counts in
    // the next window, so the fourth error of that window is bit 120.
    do_reset();
    ec = 16'd0;
    for (int n = 1; n <= 200; n++) begin
      gen_bit(b);
      inj = (n == 60) || (n == 70) || (n == 80) || (n == 93) ||
            (n == 100) || (n == 110) || (n == 120);
      if (inj) ec = ec + 16'd1;
      es = (n < 120) ? acq(n) : acq(n - 120);
      drive(1'b1, b ^ inj, 1'b1, 1'b0, es, inj, 1'b1 && (n == 120), ec, "window_wrap");
    end

    // All-zero stream never leaves SEED.
    do_reset();
    for (int n = 1; n <= 200; n++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, SEED, 1'b0, 1'b0, 16'd0, "all_zero");
    end

    // 50% valid gaps; clear_cnt coincident with an error yields a count of 1.
    do_reset();
    v  = 0;
    ec = 16'd0;
    while (v < 70) begin
      gen_bit(b);
      v++;
      inj = (v == 35) || (v == 45);
      clr = (v == 45);
      if (inj) ec = clr ? 16'd1 : ec + 16'd1;
      drive(1'b1, b ^ inj, 1'b1, clr, acq(v), inj, 1'b0, ec, "gap_valid");
      // idle cycle: random data ignored; clear_cnt alone after bit 50
      clr = (v == 50);
      if (clr) ec = 16'd0;
      drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, clr, acq(v), 1'b0, 1'b0, ec, "gap_idle");
    end

    // Reset while locked with err_count=3, then relock on the continuing stream.
    do_reset();
    ec = 16'd0;
    for (int n = 1; n <= 150; n++) begin
      gen_bit(b);
      inj = (n == 60) || (n == 70) || (n == 80);
      if (inj) ec = ec + 16'd1;
      drive(1'b1, b ^ inj, 1'b1, 1'b0, acq(n), inj, 1'b0, ec, "pre_reset");
    end
    drive(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0, SEED, 1'b0, 1'b0, 16'd0, "mid_reset");
    for (int m = 1; m <= 40; m++) begin
      gen_bit(b);
      drive(1'b1, b, 1'b1, 1'b0, acq(m), 1'b0, 1'b0, 16'd0, "relock");
    end

    // ---------------- final report ----------------
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Receive-side counterpart of the team's 13-bit Fibonacci LFSR generator.
- Consumes the serial bit stream the generator emits (the new bit in bit 0 on each shift).
- Self-synchronises to the stream, then verifies every subsequent bit against the predicted sequence.
- Reports lock status, per-bit errors and a saturating error count; err_count[3:0] is meant to drive the existing hex display.

Parameters:
- WIDTH, 13: LFSR length.
- TAPS, 13'h100D: feedback tap mask (bits 12, 3, 2, 0).
- GOOD_LEN, 16: consecutive correct predictions required to declare lock.
- WINDOW, 64: valid-bit window used for loss-of-lock evaluation.
- ERR_THRESH, 4: errors within one window that drop lock.
- CNT_W, 16: width of err_count.

Ports:
- clock  in  1  rising-edge system clock.
- reset  in  1  synchronous, active-low reset.
- in_bit  in  1  received stream bit.
- in_valid  in  1  in_bit is sampled only when high.
- clear_cnt  in  1  synchronous clear of err_count.
- locked  out  1  checker is in LOCKED.
- bit_err  out  1  one-cycle pulse per mismatched bit in LOCKED.
- lock_lost  out  1  one-cycle pulse on the LOCKED-to-SEED transition.
- err_count  out  CNT_W  saturating count of bit errors.

Behaviour:
- Reset: while reset=0 at a clock edge:
  - state=SEED; shift register, seed/good/window counters = 0.
  - Outputs: locked=0, bit_err=0, lock_lost=0, err_count=0.
  - Reset takes effect from any state, mid-operation included.
- Shift register sr[WIDTH-1:0]: sr[0] is the newest bit.
  - Prediction: exp = XOR of (sr & TAPS), i.e. sr[12]^sr[3]^sr[2]^sr[0].
  - Update: sr <= {sr[WIDTH-2:0], b}.
- Cycles with in_valid=0: no state, counter or sr change; pulses are 0.
- SEED state:
  - Each valid bit shifts in the received bit and increments seed_cnt.
  - When seed_cnt reaches WIDTH, go to VERIFY, clear good_cnt.
  - If the resulting sr is all zero, restart the seed (seed_cnt=0) and stay in SEED.
- VERIFY state: each valid bit shifts in the received bit.
  - If in_bit==exp: good_cnt++. When good_cnt reaches GOOD_LEN, go to LOCKED, locked=1 and clear the window counters.
  - If in_bit!=exp: go to SEED, seed_cnt=0. No bit_err, no count.
- LOCKED state:
  - Each valid bit shifts in exp, not in_bit, so single errors do not propagate.
  - On mismatch: bit_err=1 next cycle, err_count++ (saturates at all-ones), win_err++.
  - win_cnt counts valid bits 0..WINDOW-1. On wrap, win_err restarts; an error on the wrap bit counts as 1 in the new window.
  - When win_err reaches ERR_THRESH: go to SEED, locked=0, lock_lost=1 for one cycle, seed_cnt=0.
- Latency: all outputs are registered and reflect the valid bit sampled at the previous edge.
- clear_cnt has priority over increment. A simultaneous error yields err_count=1.
- err_count is not cleared by loss of lock; only reset or clear_cnt clears it.

Decomposition:
- Shared package prbs_pkg holds:
  - the state enum {SEED, VERIFY, LOCKED};
  - constants LFSR13_TAPS=13'h100D and LFSR13_WIDTH=13, shared with the generator.
- One sub-module, lfsr_predict: combinational parity of sr & TAPS, reusable by the generator.
- Counters and FSM stay in prbs_checker.

Test Plan:
- Lock acquisition: generator reset to 13'h000F, in_valid=1 every cycle -> locked=1 on the cycle after the 29th bit (13 seed + 16 good); err_count=0 after 1000 bits.
- Single error: invert bit 200 of the locked stream -> one bit_err pulse, err_count=1, locked stays 1, no further errors.
- Loss of lock: invert bits 300, 310, 320, 330 (one window) -> bit_err x4, err_count=4, lock_lost pulse after bit 330, locked=0; relocks 29 bits later.
- All-zero stream: in_bit=0 for 200 bits -> locked never asserts, state remains SEED.
- Gaps and priority: toggle in_valid 50% with clear_cnt asserted on the same edge as an error -> lock timing counts valid bits only, err_count=1.
- Reset mid-operation: drive reset=0 for one edge while LOCKED with err_count=3 -> all outputs 0 next cycle, relock after 29 valid bits.
